// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State encodings are visible on the state output and must stay fixed.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } pll_state_e;

  localparam int unsigned DefPorCycles        = 1000;
  localparam int unsigned DefLockTimeoutCycles = 50000;
  localparam int unsigned DefLockStableCycles  = 256;
  localparam int unsigned DefMaxRetries        = 3;

  // Counter width large enough for the longest interval, with one spare bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return int'($clog2(m)) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronously reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and downstream reset release, with
// bounded retries on lock timeout and a sticky failure state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES          = DefPorCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
  parameter int unsigned MAX_RETRIES         = DefMaxRetries
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned CntW =
      cnt_width(POR_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  // Each interval ends on the cycle its counter shows length-1.
  localparam logic [CntW-1:0] PorLast     = CntW'(POR_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};
  localparam logic [1:0]      MaxRetries  = 2'(MAX_RETRIES);

  logic locked_s;

  sync_2ff u_sync_locked (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  pll_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic            fail_q, fail_d;
  logic            lock_lost_q, lock_lost_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            entering;

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    fail_d      = fail_q;
    lock_lost_d = 1'b0;

    if (soft_reset_req) begin
      // Restart wins over any lock or timeout event in the same cycle.
      state_d = StHold;
      retry_d = 2'd0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == PorLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            if (retry_q < MaxRetries) begin
              state_d = StHold;
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = StFail;
              fail_d  = 1'b1;
            end
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_d = StWaitLock;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!locked_s) begin
            state_d     = StHold;
            lock_lost_d = 1'b1;
          end
        end
        StFail: begin
          fail_d = 1'b1;
        end
        default: begin
          state_d = StHold;
        end
      endcase
    end

    if (state_d == StRun) retry_d = 2'd0;

    // Re-entering HOLD on a soft reset also restarts the POR interval.
    entering = (state_d != state_q) || soft_reset_req;
    if (entering) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    pll_rst_d   = (state_d == StHold) || (state_d == StFail);
    sys_rst_n_d = (state_d == StRun);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign lock_lost = lock_lost_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scenarios plus a randomized run, all cross-checked every cycle
// against a phase/elapsed-time model of the sequencer.
module tb_pll_reset_sequencer;

  localparam int POR = 8;
  localparam int TO  = 64;
  localparam int ST  = 4;
  localparam int RET = 2;

  localparam int PHold = 0;
  localparam int PWait = 1;
  localparam int PStab = 2;
  localparam int PRun  = 3;
  localparam int PFail = 4;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  pll_reset_sequencer #(
    .POR_CYCLES          (POR),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .MAX_RETRIES         (RET)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .lock_lost      (lock_lost),
    .fail           (fail),
    .retry_cnt      (retry_cnt),
    .state          (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int tests = 0;
  int fails = 0;

  // Model: current phase, cycles spent in it, and the lock input history
  // (the sequencer reacts to what pll_locked was two edges earlier).
  int m_phase = PHold;
  int m_el    = 0;
  int m_retry = 0;
  bit m_fail  = 1'b0;
  bit m_ll    = 1'b0;
  bit lk_hist[$] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit ls;
    int nxt;
    bit restart;
    ls      = lk_hist[1];
    restart = 1'b0;
    if (!rst_n) begin
      m_phase = PHold;
      m_el    = 0;
      m_retry = 0;
      m_fail  = 1'b0;
      m_ll    = 1'b0;
      lk_hist = '{1'b0, 1'b0};
    end else begin
      lk_hist.push_front(pll_locked);
      void'(lk_hist.pop_back());
      m_ll = 1'b0;
      nxt  = m_phase;
      if (soft_reset_req) begin
        nxt     = PHold;
        m_retry = 0;
        m_fail  = 1'b0;
        restart = 1'b1;
      end else begin
        case (m_phase)
          PHold: if (m_el + 1 == POR) nxt = PWait;
          PWait: begin
            if (ls) nxt = PStab;
            else if (m_el + 1 == TO) begin
              if (m_retry < RET) begin
                nxt = PHold;
                m_retry++;
              end else begin
                nxt    = PFail;
                m_fail = 1'b1;
              end
            end
          end
          PStab: begin
            if (!ls) nxt = PWait;
            else if (m_el + 1 == ST) begin
              nxt     = PRun;
              m_retry = 0;
            end
          end
          PRun: if (!ls) begin
            nxt  = PHold;
            m_ll = 1'b1;
          end
          default: ;
        endcase
      end
      m_el    = (restart || nxt != m_phase) ? 0 : m_el + 1;
      m_phase = nxt;
    end
  endtask

  task automatic check_all();
    check("state", state, m_phase);
    check("pll_rst", pll_rst, (m_phase == PHold || m_phase == PFail) ? 1 : 0);
    check("sys_rst_n", sys_rst_n, (m_phase == PRun) ? 1 : 0);
    check("lock_lost", lock_lost, m_ll);
    check("fail", fail, m_fail);
    check("retry_cnt", retry_cnt, m_retry);
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
    check_all();
  endtask

  int  n;
  bit  saw_wait;
  bit  saw_rel;
  int  seg;
  bit  lvl;

  initial begin
    rst_n          = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    repeat (3) tick();
    check("rst_state", state, PHold);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);

    // Power-on hold length.
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pll_rst === 1'b1 && n < 100);
    check("por_len", n, POR);
    check("por_state", state, PWait);

    // Lock to release latency.
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
    check("release_latency", n, 7);
    check("release_state", state, PRun);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (lock_lost !== 1'b1 && n < 20);
    check("lost_latency", n, 3);
    check("lost_sys_rst_n", sys_rst_n, 0);
    check("lost_state", state, PHold);
    tick();
    check("lost_pulse_end", lock_lost, 0);

    // Glitch during STABLE, then re-lock.
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (state !== 3'(PStab) && n < 100);
    check("reach_stable", state, PStab);
    pll_locked = 1'b0;
    saw_wait = 1'b0;
    saw_rel  = 1'b0;
    repeat (3) begin
      tick();
      if (sys_rst_n === 1'b1) saw_rel = 1'b1;
      if (state === 3'(PWait)) saw_wait = 1'b1;
    end
    check("glitch_to_wait", saw_wait, 1);
    check("glitch_no_release", saw_rel, 0);
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
    check("relock_latency", n, 7);

    // Exhaust retries.
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (retry_cnt !== 2'd1 && n < 300);
    check("retry_1", retry_cnt, 1);
    check("retry_1_state", state, PHold);
    n = 0;
    do begin tick(); n++; end while (retry_cnt !== 2'd2 && n < 300);
    check("retry_2", retry_cnt, 2);
    n = 0;
    do begin tick(); n++; end while (state !== 3'(PFail) && n < 300);
    check("fail_state", state, PFail);
    check("fail_flag", fail, 1);
    check("fail_pll_rst", pll_rst, 1);
    repeat (5) tick();
    check("fail_sticky", fail, 1);
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check("soft_state", state, PHold);
    check("soft_fail", fail, 0);
    check("soft_retry", retry_cnt, 0);

    // Soft reset coincident with a timeout.
    n = 0;
    do begin tick(); n++; end while (retry_cnt !== 2'd1 && n < 300);
    check("pre_coinc_retry", retry_cnt, 1);
    n = 0;
    do begin tick(); n++; end while (!(m_phase == PWait && m_el == TO - 1) && n < 300);
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check("coinc_state", state, PHold);
    check("coinc_retry", retry_cnt, 0);

    // Hard reset while in RUN.
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (state !== 3'(PRun) && n < 300);
    check("reach_run", state, PRun);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("hard_rst_state", state, PHold);
    check("hard_rst_sys", sys_rst_n, 0);
    check("hard_rst_pll", pll_rst, 1);

    // Randomized lock behaviour with occasional soft and hard resets.
    seg = 0;
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        seg = $urandom_range(1, 90);
      end
      seg--;
      pll_locked     = lvl;
      soft_reset_req = ($urandom_range(0, 199) == 0);
      rst_n          = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n          = 1'b1;
    soft_reset_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
